// File: rtl/vme_rd_responder.sv
// vme_rd_responder
//   Slave-side model of the VME read channel. Read commands (addr, len, tag)
//   are queued in a small FIFO. A burst engine then returns len+1 64-bit beats
//   from an internal word memory, in order, each carrying the command's tag
//   and a last flag on the final beat. A backdoor port preloads the memory.
//
// Parameters
//   MEM_DEPTH_LOG2 : memory holds 2^MEM_DEPTH_LOG2 64-bit words
//   CMD_DEPTH      : command FIFO entries (power of two, >= 2)
//
// Ports
//   clock, reset                 : clock, synchronous active-high reset
//   io_vme_rd_cmd_*              : command channel (valid/ready, addr, len, tag)
//   io_vme_rd_data_*             : beat channel (valid/ready, data, tag, last)
//   io_mem_wr_en/addr/data       : backdoor memory write
//
// Build option
//   VME_RD_RESP_STALL_EN : when defined, a 16-bit LFSR injects deterministic
//                          stalls on slot loads and on cmd_ready.
module vme_rd_responder #(
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int CMD_DEPTH      = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      io_vme_rd_cmd_valid,
  output logic                      io_vme_rd_cmd_ready,
  input  logic [31:0]               io_vme_rd_cmd_bits_addr,
  input  logic [7:0]                io_vme_rd_cmd_bits_len,
  input  logic [20:0]               io_vme_rd_cmd_bits_tag,
  output logic                      io_vme_rd_data_valid,
  input  logic                      io_vme_rd_data_ready,
  output logic [63:0]               io_vme_rd_data_bits_data,
  output logic [20:0]               io_vme_rd_data_bits_tag,
  output logic                      io_vme_rd_data_bits_last,
  input  logic                      io_mem_wr_en,
  input  logic [MEM_DEPTH_LOG2-1:0] io_mem_wr_addr,
  input  logic [63:0]               io_mem_wr_data
);

  localparam int PTR_W     = $clog2(CMD_DEPTH);
  localparam int MEM_WORDS = 1 << MEM_DEPTH_LOG2;

  typedef enum logic {IDLE, ACTIVE} stateT;

  // ---------------------------------------------------------------------------
  // Word memory (never reset; read combinationally, so a same-cycle write
  // to the word being read returns the old contents)
  // ---------------------------------------------------------------------------
  logic [63:0] mem [MEM_WORDS];

  always_ff @(posedge clock) begin
    if (io_mem_wr_en) begin
      mem[io_mem_wr_addr] <= io_mem_wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Stall source
  // ---------------------------------------------------------------------------
  logic stallLoad;
  logic cmdBlock;

`ifdef VME_RD_RESP_STALL_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16,14,13,11
  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign stallLoad = (lfsr[1:0] == 2'b00);
  assign cmdBlock  = (lfsr[3:2] == 2'b00);
`else
  assign stallLoad = 1'b0;
  assign cmdBlock  = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Command FIFO (pointers carry one extra wrap bit to tell full from empty)
  // ---------------------------------------------------------------------------
  logic [MEM_DEPTH_LOG2-1:0] fifoIdx [CMD_DEPTH];
  logic [7:0]                fifoLen [CMD_DEPTH];
  logic [20:0]               fifoTag [CMD_DEPTH];
  logic [PTR_W:0]            wrPtr;
  logic [PTR_W:0]            rdPtr;
  logic                      fifoEmpty;
  logic                      fifoFull;
  logic                      cmdReady;
  logic                      cmdPush;
  logic [MEM_DEPTH_LOG2-1:0] cmdIdx;
  logic                      unusedAddrBits;

  assign cmdIdx         = io_vme_rd_cmd_bits_addr[3+MEM_DEPTH_LOG2-1:3];
  assign unusedAddrBits = ^{io_vme_rd_cmd_bits_addr[31:3+MEM_DEPTH_LOG2],
                            io_vme_rd_cmd_bits_addr[2:0]};

  assign fifoEmpty = (wrPtr == rdPtr);
  assign fifoFull  = (wrPtr[PTR_W] != rdPtr[PTR_W]) &&
                     (wrPtr[PTR_W-1:0] == rdPtr[PTR_W-1:0]);
  // Depends only on registered state, so data_ready never reaches cmd_ready.
  assign cmdReady  = !fifoFull && !cmdBlock;
  assign cmdPush   = io_vme_rd_cmd_valid && cmdReady;

  assign io_vme_rd_cmd_ready = cmdReady;

  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr <= '0;
    end else if (cmdPush) begin
      fifoIdx[wrPtr[PTR_W-1:0]] <= cmdIdx;
      fifoLen[wrPtr[PTR_W-1:0]] <= io_vme_rd_cmd_bits_len;
      fifoTag[wrPtr[PTR_W-1:0]] <= io_vme_rd_cmd_bits_tag;
      wrPtr                     <= wrPtr + (PTR_W+1)'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Burst engine with a single registered output slot
  // ---------------------------------------------------------------------------
  stateT                     state;
  logic [MEM_DEPTH_LOG2-1:0] baseIdx;
  logic [7:0]                burstLen;
  logic [20:0]               burstTag;
  logic [7:0]                cnt;
  logic [MEM_DEPTH_LOG2-1:0] rdIdx;
  logic                      slotFree;
  logic                      dataValid;
  logic [63:0]               dataBits;
  logic [20:0]               dataTag;
  logic                      dataLast;

  // Index arithmetic is MEM_DEPTH_LOG2 bits wide and wraps silently.
  assign rdIdx    = baseIdx + MEM_DEPTH_LOG2'(cnt);
  assign slotFree = !dataValid || io_vme_rd_data_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      rdPtr     <= '0;
      baseIdx   <= '0;
      burstLen  <= '0;
      burstTag  <= '0;
      cnt       <= '0;
      dataValid <= 1'b0;
      dataBits  <= '0;
      dataTag   <= '0;
      dataLast  <= 1'b0;
    end else begin
      // Drain the slot on handshake; a load below overrides this.
      if (dataValid && io_vme_rd_data_ready) begin
        dataValid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!fifoEmpty) begin
            baseIdx  <= fifoIdx[rdPtr[PTR_W-1:0]];
            burstLen <= fifoLen[rdPtr[PTR_W-1:0]];
            burstTag <= fifoTag[rdPtr[PTR_W-1:0]];
            rdPtr    <= rdPtr + (PTR_W+1)'(1);
            cnt      <= '0;
            state    <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (slotFree && !stallLoad) begin
            dataValid <= 1'b1;
            dataBits  <= mem[rdIdx];
            dataTag   <= burstTag;
            dataLast  <= (cnt == burstLen);
            // Compare before increment so len=255 never wraps cnt.
            if (cnt == burstLen) begin
              state <= IDLE;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
      endcase
    end
  end

  assign io_vme_rd_data_valid     = dataValid;
  assign io_vme_rd_data_bits_data = dataBits;
  assign io_vme_rd_data_bits_tag  = dataTag;
  assign io_vme_rd_data_bits_last = dataLast;

endmodule

// File: tb/tb_vme_rd_responder.sv
module tb_vme_rd_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmdValid;
  logic        cmdReady;
  logic [31:0] cmdAddr;
  logic [7:0]  cmdLen;
  logic [20:0] cmdTag;
  logic        dataValid;
  logic        dataReady;
  logic [63:0] dataBits;
  logic [20:0] dataTag;
  logic        dataLast;
  logic        memWrEn;
  logic [3:0]  memWrAddr;
  logic [63:0] memWrData;

  int total = 0;
  int bad   = 0;

  logic [63:0] memModel [16];

  vme_rd_responder #(
    .MEM_DEPTH_LOG2(4),
    .CMD_DEPTH     (2)
  ) dut (
    .clock                   (clock),
    .reset                   (reset),
    .io_vme_rd_cmd_valid     (cmdValid),
    .io_vme_rd_cmd_ready     (cmdReady),
    .io_vme_rd_cmd_bits_addr (cmdAddr),
    .io_vme_rd_cmd_bits_len  (cmdLen),
    .io_vme_rd_cmd_bits_tag  (cmdTag),
    .io_vme_rd_data_valid    (dataValid),
    .io_vme_rd_data_ready    (dataReady),
    .io_vme_rd_data_bits_data(dataBits),
    .io_vme_rd_data_bits_tag (dataTag),
    .io_vme_rd_data_bits_last(dataLast),
    .io_mem_wr_en            (memWrEn),
    .io_mem_wr_addr          (memWrAddr),
    .io_mem_wr_data          (memWrData)
  );

  always #5 clock = ~clock;

  task automatic checkVal(input string tagName, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tagName, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sendCmd(input logic [31:0] a, input logic [7:0] l, input logic [20:0] t);
    cmdValid = 1'b1;
    cmdAddr  = a;
    cmdLen   = l;
    cmdTag   = t;
    tick();
    cmdValid = 1'b0;
  endtask

  task automatic memWrite(input logic [3:0] a, input logic [63:0] d);
    memWrEn   = 1'b1;
    memWrAddr = a;
    memWrData = d;
    tick();
    memWrEn   = 1'b0;
  endtask

  task automatic expectBeat(input string name, input int idx, input logic [20:0] t, input logic last);
    checkVal({name, ".valid"}, dataValid, 1);
    checkVal({name, ".data"}, dataBits, memModel[idx]);
    checkVal({name, ".tag"}, dataTag, t);
    checkVal({name, ".last"}, dataLast, last);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int cyc;
    logic newReady;

    reset     = 1'b1;
    cmdValid  = 1'b0;
    cmdAddr   = '0;
    cmdLen    = '0;
    cmdTag    = '0;
    dataReady = 1'b0;
    memWrEn   = 1'b0;
    memWrAddr = '0;
    memWrData = '0;

    // Reset values
    tick();
    tick();
    checkVal("rst.cmdReady", cmdReady, 1);
    checkVal("rst.valid", dataValid, 0);
    checkVal("rst.data", dataBits, 0);
    checkVal("rst.tag", dataTag, 0);
    checkVal("rst.last", dataLast, 0);
    reset = 1'b0;

    // Preload mem[k] = k * 0x0101010101010101
    for (int k = 0; k < 16; k++) begin
      memModel[k] = 64'h0101010101010101 * 64'(k);
      memWrite(4'(k), memModel[k]);
    end

    // A: addr 0x10 (index 2), len 3, tag 5, ready held high
    dataReady = 1'b1;
    sendCmd(32'h10, 8'd3, 21'h5);
    checkVal("A.T0valid", dataValid, 0);
    tick();
    checkVal("A.T1valid", dataValid, 0);
    for (int b = 0; b < 4; b++) begin
      tick();
      expectBeat("A", 2 + b, 21'h5, (b == 3));
    end
    tick();
    checkVal("A.after", dataValid, 0);

    // B: back-to-back len=0 commands, one bubble between beats
    cmdValid = 1'b1;
    cmdAddr  = 32'h20;
    cmdLen   = 8'd0;
    cmdTag   = 21'h1;
    checkVal("B.rdy0", cmdReady, 1);
    tick();
    cmdAddr = 32'h28;
    cmdTag  = 21'h2;
    checkVal("B.rdy1", cmdReady, 1);
    tick();
    cmdValid = 1'b0;
    checkVal("B.rdy2", cmdReady, 1);
    checkVal("B.T1valid", dataValid, 0);
    tick();
    expectBeat("B1", 4, 21'h1, 1'b1);
    tick();
    checkVal("B.bubble", dataValid, 0);
    tick();
    expectBeat("B2", 5, 21'h2, 1'b1);
    tick();
    checkVal("B.after", dataValid, 0);

    // C: len 7 from index 8 with data_ready toggling
    dataReady = 1'b0;
    sendCmd(32'h40, 8'd7, 21'h1ABCD);
    n   = 0;
    cyc = 0;
    while (n < 8 && cyc < 100) begin
      newReady  = cyc[0];
      dataReady = newReady;
      if (dataValid) begin
        expectBeat("C", 8 + n, 21'h1ABCD, (n == 7));
        if (newReady) n++;
      end
      tick();
      cyc++;
    end
    checkVal("C.beats", n, 8);
    dataReady = 1'b1;
    checkVal("C.after0", dataValid, 0);
    tick();
    checkVal("C.after1", dataValid, 0);

    // D: address wrap, index 15 then 0, 1
    sendCmd(32'h78, 8'd2, 21'h77);
    tick();
    for (int b = 0; b < 3; b++) begin
      tick();
      expectBeat("D", (15 + b) % 16, 21'h77, (b == 2));
    end
    tick();
    checkVal("D.after", dataValid, 0);

    // E: fill FIFO with data_ready low, then reset mid-burst
    dataReady = 1'b0;
    checkVal("E.rdy0", cmdReady, 1);
    sendCmd(32'h08, 8'd3, 21'hA);
    checkVal("E.rdy1", cmdReady, 1);
    sendCmd(32'h50, 8'd0, 21'hB);
    checkVal("E.rdy2", cmdReady, 1);
    sendCmd(32'h58, 8'd0, 21'hC);
    checkVal("E.full", cmdReady, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkVal("E.fullHold", cmdReady, 0);
      expectBeat("E.stuck", 1, 21'hA, 1'b0);
    end
    reset = 1'b1;
    tick();
    checkVal("E.rstValid", dataValid, 0);
    checkVal("E.rstReady", cmdReady, 1);
    checkVal("E.rstData", dataBits, 0);
    checkVal("E.rstLast", dataLast, 0);
    reset     = 1'b0;
    dataReady = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checkVal("E.noStale", dataValid, 0);
    end
    sendCmd(32'h30, 8'd0, 21'h3);
    tick();
    tick();
    expectBeat("E.new", 6, 21'h3, 1'b1);

    // F: backdoor write to word 3 on the cycle its beat loads
    sendCmd(32'h18, 8'd0, 21'hF);
    tick();
    memWrEn   = 1'b1;
    memWrAddr = 4'd3;
    memWrData = 64'hDEADBEEF00000003;
    tick();
    memWrEn = 1'b0;
    expectBeat("F.old", 3, 21'hF, 1'b1);
    memModel[3] = 64'hDEADBEEF00000003;
    tick();
    checkVal("F.after", dataValid, 0);
    sendCmd(32'h18, 8'd0, 21'h10);
    tick();
    tick();
    expectBeat("F.new", 3, 21'h10, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vme_rd_responder.md
# vme_rd_responder

Slave-side model of the VME read channel: accepts read commands (addr, len, tag), fetches `len+1` 64-bit beats from an internal word memory, and returns them in order with the command's tag and a `last` flag. It sits on the memory side of the VME read interface, facing tensor/uop load clients, and serves as the DRAM stand-in in block-level benches and small integrations. A backdoor write port preloads memory contents.

## Interface
Parameters:
- `MEM_DEPTH_LOG2`, default 10: memory holds 2^MEM_DEPTH_LOG2 64-bit words.
- `CMD_DEPTH`, default 2: command FIFO entries (power of two, ≥2).

Ports:
- Clocking: one clock; reset is synchronous and active-high (ports `clock`, `reset`).
- `clock` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `io_vme_rd_cmd_valid` in 1: command offered.
- `io_vme_rd_cmd_ready` out 1: command FIFO not full.
- `io_vme_rd_cmd_bits_addr` in 32: byte address, 8-byte aligned.
- `io_vme_rd_cmd_bits_len` in 8: beats minus one.
- `io_vme_rd_cmd_bits_tag` in 21: echoed on every returned beat.
- `io_vme_rd_data_valid` out 1: beat available.
- `io_vme_rd_data_ready` in 1: client accepts beat.
- `io_vme_rd_data_bits_data` out 64: beat payload.
- `io_vme_rd_data_bits_tag` out 21: tag of the owning command.
- `io_vme_rd_data_bits_last` out 1: final beat of the burst.
- `io_mem_wr_en` in 1: backdoor write strobe.
- `io_mem_wr_addr` in MEM_DEPTH_LOG2: word index.
- `io_mem_wr_data` in 64: write data.

## Operation
- Command FIFO: enqueue on `cmd_valid && cmd_ready`; `cmd_ready = !full`.
- Word index = `addr[3+MEM_DEPTH_LOG2-1:3]`. `addr[2:0]` and bits above the index are ignored.
- Burst engine FSM:
  - IDLE: if FIFO non-empty, pop, latch base/len/tag, clear beat counter `cnt`, go ACTIVE. No beat is produced in this cycle.
  - ACTIVE: when the output slot is free (`!data_valid || data_ready`), load the slot with `mem[(base+cnt) mod 2^MEM_DEPTH_LOG2]`, the tag, and `last = (cnt == len)`. If last, go IDLE; else increment `cnt`.
- Address wrap: index arithmetic is MEM_DEPTH_LOG2 bits wide and wraps silently.
- Output slot is a single register. Data, tag, and last hold stable while `valid && !ready`.
- Memory read is combinational into the slot. A backdoor write to the same word in the same cycle returns the old value. Writes are legal at any time.
- `len = 255` produces 256 beats. `cnt` is 8 bits and must not overflow before the compare.
- Reset: FIFO emptied, FSM to IDLE, `cnt` cleared. Memory contents are not cleared. A burst in progress is abandoned with no further beats.

## Timing
- Output values during/after reset: `cmd_ready=1`, `data_valid=0`, `data_bits_data=0`, `data_bits_tag=0`, `data_bits_last=0`.
- Command accepted at edge of cycle T. Pop happens in T+1. First beat is valid in T+2.
- With `data_ready` held high, beats stream one per cycle.
- Between back-to-back bursts there is exactly one bubble cycle: the IDLE pop cycle.
- Commands can be accepted while a burst streams. FIFO full with burst active deasserts `cmd_ready` until the next pop.
- No combinational path exists from `data_ready` to `cmd_ready`, or from any input to `data_valid`.

## Configuration
- `VME_RD_RESP_STALL_EN`:
  - Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 0xACE1 at reset) advances every cycle. When `lfsr[1:0]==0`, the engine must not load the output slot that cycle. When `lfsr[3:2]==0`, `cmd_ready` is forced low. Used for deterministic backpressure stress.
  - Undefined: no LFSR exists and the timing above holds exactly.

## Test plan
- Preload `mem[k]=k*0x0101010101010101` for k=0..15. Issue cmd addr=0x10, len=3, tag=0x5, ready held high → beats `mem[2..5]` in cycles T+2..T+5, tag 0x5 on every beat, last only on the 4th beat.
- Issue two cmds back-to-back (tags 1 and 2, len=0) → cmd_ready stays 1. Beat tag 1 at T+2, bubble, beat tag 2 at T+4.
- Issue len=7, toggle `data_ready` every other cycle → no beat lost or duplicated; data stays stable while stalled; 8 beats in order.
- `MEM_DEPTH_LOG2=4`, addr=0x78 (index 15), len=2 → indices 15, 0, 1.
- Fill FIFO (CMD_DEPTH+1 cmds while data_ready=0) → cmd_ready=0 until the first pop. Then assert reset mid-burst → `data_valid=0` next cycle, FIFO empty; a new cmd afterwards returns the correct preloaded data.
- Backdoor write to word 3 in the same cycle its beat loads → old value returned; a following read returns the new value.
